// File: rtl/vga_pkg.sv
// Shared definitions for the VGA VRAM path: host FSM encoding and the
// default starvation bound used by the arbiter.
package vga_pkg;

   typedef enum logic [1:0] {
      HOST_IDLE   = 2'd0,
      HOST_PEND   = 2'd1,
      HOST_ISSUED = 2'd2
   } host_state_e;

   localparam int STARVE_LIMIT_DEF = 16;

endpackage

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: the readout port wins by default, and the host port
// is forced through once it has waited STARVE_LIMIT-1 readout grants.
//
// state       | meaning
// ------------|-----------------------------------------------------------
// HOST_IDLE   | no host request in flight; hostReq is captured here
// HOST_PEND   | host request captured, waiting for (or being given) the port
// HOST_ISSUED | host access hit the VRAM last edge; hostAck pulses this cycle
module vram_arbiter
   import vga_pkg::*;
#(
   parameter int ADDR_W       = 13,
   parameter int DATA_W       = 8,
   parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rdReq,
   input  logic [ADDR_W-1:0] rdAddr,
   output logic              rdValid,
   output logic [DATA_W-1:0] rdData,
   output logic              rdDropped,
   input  logic              hostReq,
   input  logic              hostWe,
   input  logic [ADDR_W-1:0] hostAddr,
   input  logic [DATA_W-1:0] hostWrData,
   output logic              hostAck,
   output logic [DATA_W-1:0] hostRdData,
   output logic              starveErr,
   output logic [ADDR_W-1:0] memAddr,
   output logic              memWe,
   output logic [DATA_W-1:0] memWrData,
   input  logic [DATA_W-1:0] memRdData
);

   localparam int              CNT_W    = $clog2(STARVE_LIMIT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STARVE_LIMIT - 1);

   host_state_e       state_q, state_d;
   logic [CNT_W-1:0]  wait_q, wait_d;
   logic              pend_we_q;
   logic [ADDR_W-1:0] pend_addr_q, mem_addr_q;
   logic [DATA_W-1:0] pend_data_q, mem_wdata_q, rd_data_q, host_rd_q;
   logic              rd_valid_q, dropped_q, starve_q;
   logic              capture, host_grant, force_grant, rd_grant;

   always_comb begin
      state_d     = state_q;
      wait_d      = wait_q;
      capture     = 1'b0;
      host_grant  = 1'b0;
      force_grant = 1'b0;
      case (state_q)
         HOST_IDLE: begin
            if (hostReq) begin
               capture = 1'b1;
               wait_d  = '0;
               state_d = HOST_PEND;
            end
         end
         HOST_PEND: begin
            if (!rdReq) begin
               host_grant = 1'b1;
               state_d    = HOST_ISSUED;
            end else if (wait_q == CNT_LAST) begin
               host_grant  = 1'b1;
               force_grant = 1'b1;
               state_d     = HOST_ISSUED;
            end else begin
               wait_d = wait_q + 1'b1;
            end
         end
         HOST_ISSUED: state_d = HOST_IDLE;
         default:     state_d = HOST_IDLE;
      endcase
      // readout is kept off the bus while reset is asserted so memAddr reads 0
      rd_grant = rdReq & ~host_grant & ~rst;
   end

   assign memAddr    = host_grant ? pend_addr_q : (rd_grant ? rdAddr : mem_addr_q);
   assign memWe      = host_grant & pend_we_q;
   assign memWrData  = host_grant ? pend_data_q : mem_wdata_q;
   assign rdValid    = rd_valid_q;
   assign rdData     = rd_valid_q ? memRdData : rd_data_q;
   assign hostAck    = (state_q == HOST_ISSUED);
   assign hostRdData = (hostAck & ~pend_we_q) ? memRdData : host_rd_q;
   assign rdDropped  = dropped_q;
   assign starveErr  = starve_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= HOST_IDLE;
         wait_q      <= '0;
         pend_we_q   <= 1'b0;
         pend_addr_q <= '0;
         pend_data_q <= '0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         rd_valid_q  <= 1'b0;
         rd_data_q   <= '0;
         host_rd_q   <= '0;
         dropped_q   <= 1'b0;
         starve_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         if (capture) begin
            pend_we_q   <= hostWe;
            pend_addr_q <= hostAddr;
            pend_data_q <= hostWrData;
         end
         if (host_grant | rd_grant) mem_addr_q <= memAddr;
         if (host_grant) mem_wdata_q <= memWrData;
         rd_valid_q <= rd_grant;
         if (rd_valid_q) rd_data_q <= memRdData;
         if (hostAck & ~pend_we_q) host_rd_q <= memRdData;
         dropped_q <= force_grant;
         if (force_grant) starve_q <= 1'b1;
      end
   end

endmodule

// File: doc/vram_arbiter.md
VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 Parameter ADDR_W, default 13, VRAM address width.
REQ-002 Parameter DATA_W, default 8, VRAM data width.
REQ-003 Parameter STARVE_LIMIT, default 16, max cycles a pending host request waits before forced grant (range 2..255).
REQ-004 Clocking: one clock; reset is asynchronous and active-high.
REQ-005 clk  in  1  VGA dot clock; all state on rising edge.
REQ-006 rst  in  1  asynchronous active-high reset.
REQ-007 rdReq  in  1  readout requests port this cycle.
REQ-008 rdAddr  in  ADDR_W  readout address, valid with rdReq.
REQ-009 rdValid  out  1  readout data valid (1 cycle after rdReq grant).
REQ-010 rdData  out  DATA_W  readout data, valid with rdValid.
REQ-011 rdDropped  out  1  one-cycle pulse: rdReq refused due to forced host grant.
REQ-012 hostReq  in  1  host access request, level.
REQ-013 hostWe  in  1  1 = write, 0 = read; sampled with hostReq.
REQ-014 hostAddr  in  ADDR_W  host address; sampled with hostReq.
REQ-015 hostWrData  in  DATA_W  host write data; sampled with hostReq.
REQ-016 hostAck  out  1  one-cycle completion pulse.
REQ-017 hostRdData  out  DATA_W  host read data, valid with hostAck on reads.
REQ-018 starveErr  out  1  sticky: at least one forced host grant since reset.
REQ-019 memAddr  out  ADDR_W  single-port VRAM address.
REQ-020 memWe  out  1  VRAM write enable.
REQ-021 memWrData  out  DATA_W  VRAM write data.
REQ-022 memRdData  in  DATA_W  VRAM read data, 1-cycle synchronous latency.

Function
REQ-023 Host FSM states: IDLE, PEND, ISSUED; one host request in flight.
REQ-024 IDLE with hostReq=1: capture hostWe/hostAddr/hostWrData into pending regs, go to PEND, clear wait counter.
REQ-025 PEND, rdReq=0: grant host (memAddr=pending addr, memWe=pending we, memWrData=pending data), go to ISSUED.
REQ-026 PEND, rdReq=1, wait counter < STARVE_LIMIT-1: grant readout, increment wait counter, stay PEND.
REQ-027 PEND, rdReq=1, wait counter = STARVE_LIMIT-1: force host grant, pulse rdDropped next cycle, set starveErr, go to ISSUED.
REQ-028 ISSUED: hostAck=1 for exactly one cycle; on read, hostRdData=memRdData captured; go to IDLE.
REQ-029 Host back-to-back: hostReq still high in IDLE after ack is a new request; minimum host request spacing 3 cycles (capture, grant, ack).
REQ-030 hostReq dropped after capture: captured request still completes and acks.
REQ-031 Readout grant when host not granted: memAddr=rdAddr, memWe=0; rdValid=1 and rdData=memRdData next cycle.
REQ-032 Readout latency fixed at 1 cycle; rdValid never asserts without prior granted rdReq.
REQ-033 No port use: memWe=0, memAddr holds last value.
REQ-034 memWe asserts only in a host-write grant cycle; never two grants same cycle.
REQ-035 Wait counter saturates; width ceil(log2(STARVE_LIMIT)).

Reset
REQ-036 rst asserted: FSM=IDLE, wait counter=0, memAddr=0, memWe=0, memWrData=0, rdValid=0, rdData=0, rdDropped=0, hostAck=0, hostRdData=0, starveErr=0.
REQ-037 Reset mid-request discards pending host request; no hostAck issued for it.
REQ-038 First grant possible on first clock edge after rst deasserts.

Structure
REQ-039 FSM state encoding and STARVE_LIMIT default go in shared package vga_pkg.
REQ-040 Single module; no sub-modules required.

Verification
REQ-041 Host write 0x1234<-0xA5 with rdReq=0 -> memWe=1 addr 0x1234 data 0xA5 cycle 2, hostAck cycle 3.
REQ-042 Host read 0x0010 (mem holds 0x3C) while rdReq=1 every 8th cycle -> hostAck with hostRdData=0x3C, starveErr=0.
REQ-043 rdReq held 1 continuously, host write pending -> forced grant after 16 cycles, rdDropped one pulse, starveErr=1 and stays 1.
REQ-044 rdReq addr 0x0005 (mem 0x7E), no host -> rdValid=1, rdData=0x7E next cycle.
REQ-045 hostReq captured, rst asserted in PEND -> all outputs zero, no hostAck after release.
REQ-046 hostReq pulsed one cycle only -> request completes, exactly one hostAck.
